// File: rtl/dmem_port_arbiter_if.sv
// Data-memory bus between the port arbiter and the single-port memory array.
interface dmem_port_arbiter_if #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned TAM_M = 10
);
  logic             mem_en_o;
  logic [3:0]       mem_we_o;
  logic [TAM_M-1:0] mem_addr_o;
  logic [NBITS-1:0] mem_wdata_o;
  logic [NBITS-1:0] mem_rdata_i;

  // Arbiter side: issues accesses, receives read data.
  modport master (
    output mem_en_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    input  mem_rdata_i
  );

  // Memory side: accepts accesses, returns read data one cycle later.
  modport slave (
    input  mem_en_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the data memory between the MEM stage and the debug unit: byte-lane
// writes, right-aligned loads with a one-cycle stall, and req/ack debug reads.
module dmem_port_arbiter #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned TAM_M = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_mips_clk_ctrl,
  input  logic                EX_MEM_MemRead,
  input  logic                EX_MEM_MemWrite,
  input  logic [NBITS-1:0]    EX_MEM_ALU,
  input  logic [NBITS-1:0]    EX_MEM_Registro2,
  input  logic [1:0]          EX_MEM_TamanoFiltro,
  output logic                pipe_stall_o,
  output logic [NBITS-1:0]    MEM_DatoMemoria_o,
  input  logic [NBITS-1:0]    i_mips_mem_debug,
  input  logic                dbg_req_i,
  output logic                dbg_ack_o,
  output logic [NBITS-1:0]    MEM_DatoMemoriaDebug_o,
  dmem_port_arbiter_if.master mem
);
  localparam int unsigned NLANES = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {IDLE, PIPE_RD, DBG_RD, DBG_WAIT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             pv_c;
  logic             pipe_rd_c;
  logic             pipe_rd_issue_c;
  logic [3:0]       store_we_c;
  logic [NBITS-1:0] store_wdata_c;
  logic [NBITS-1:0] rd_lane_c;
  logic [1:0]       rd_size_q;
  logic [1:0]       rd_off_q;
  logic             unused_addr_bits;

  assign pv_c      = i_mips_clk_ctrl & (EX_MEM_MemRead | EX_MEM_MemWrite);
  assign pipe_rd_c = pv_c & EX_MEM_MemRead;

  // Address bits outside the word index are not decoded.
  assign unused_addr_bits = ^{EX_MEM_ALU[NBITS-1:TAM_M+2],
                              i_mips_mem_debug[NBITS-1:TAM_M+2],
                              i_mips_mem_debug[1:0]};

  // Store lane enables and lane-replicated data; misaligned low bits are ignored.
  always_comb begin
    store_we_c    = 4'b1111;
    store_wdata_c = EX_MEM_Registro2;
    case (EX_MEM_TamanoFiltro)
      2'b00: begin
        store_we_c    = 4'b0001 << EX_MEM_ALU[1:0];
        store_wdata_c = NBITS'({NLANES{EX_MEM_Registro2[BYTE_W-1:0]}});
      end
      2'b01: begin
        store_we_c    = EX_MEM_ALU[1] ? 4'b1100 : 4'b0011;
        store_wdata_c = NBITS'({2{EX_MEM_Registro2[HALF_W-1:0]}});
      end
      default: ;
    endcase
  end

  // Right-align and zero-extend the returned word for the latched load size.
  always_comb begin
    rd_lane_c = mem.mem_rdata_i;
    case (rd_size_q)
      2'b00:   rd_lane_c = NBITS'(BYTE_W'(mem.mem_rdata_i >> {rd_off_q, 3'b000}));
      2'b01:   rd_lane_c = NBITS'(HALF_W'(mem.mem_rdata_i >> {rd_off_q[1], 4'b0000}));
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, memory port and stall; pipeline wins over debug in IDLE.
  always_comb begin
    state_nxt       = state;
    mem.mem_en_o    = 1'b0;
    mem.mem_we_o    = 4'b0000;
    mem.mem_addr_o  = EX_MEM_ALU[TAM_M+1:2];
    mem.mem_wdata_o = store_wdata_c;
    pipe_stall_o    = 1'b0;
    pipe_rd_issue_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (pipe_rd_c) begin
          mem.mem_en_o    = 1'b1;
          pipe_stall_o    = 1'b1;
          pipe_rd_issue_c = 1'b1;
          state_nxt       = PIPE_RD;
        end else if (pv_c) begin
          mem.mem_en_o = 1'b1;
          mem.mem_we_o = store_we_c;
        end else if (dbg_req_i) begin
          mem.mem_en_o   = 1'b1;
          mem.mem_addr_o = i_mips_mem_debug[TAM_M+1:2];
          state_nxt      = DBG_RD;
        end
      end
      PIPE_RD: state_nxt = IDLE;
      DBG_RD: begin
        pipe_stall_o = pipe_rd_c;
        state_nxt    = DBG_WAIT;
      end
      DBG_WAIT: begin
        pipe_stall_o = pipe_rd_c;
        if (!dbg_req_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      mem.mem_en_o = 1'b0;
      mem.mem_we_o = 4'b0000;
      pipe_stall_o = 1'b0;
    end
  end

  // Load/debug data capture, debug ack pulse and latched load format.
  always_ff @(posedge clk) begin
    if (reset) begin
      MEM_DatoMemoria_o      <= '0;
      MEM_DatoMemoriaDebug_o <= '0;
      dbg_ack_o              <= 1'b0;
      rd_size_q              <= 2'b00;
      rd_off_q               <= 2'b00;
    end else begin
      dbg_ack_o <= (state == DBG_RD);
      if (pipe_rd_issue_c) begin
        rd_size_q <= EX_MEM_TamanoFiltro;
        rd_off_q  <= EX_MEM_ALU[1:0];
      end
      if (state == PIPE_RD) MEM_DatoMemoria_o <= rd_lane_c;
      if (state == DBG_RD) MEM_DatoMemoriaDebug_o <= mem.mem_rdata_i;
    end
  end
endmodule
